// File: rtl/reg_file_param.sv
// Parametrised register file with two async read ports and a shared write
// path: memory loads win, colliding register ops wait in a one-entry buffer.
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [3:0]        op,
  input  logic [AW-1:0]     dst,
  input  logic [AW-1:0]     src,
  input  logic [3:0]        imm,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              ld_valid,
  input  logic [AW-1:0]     ld_dst,
  input  logic [DATA_W-1:0] ld_data,
  output logic              stall,
  output logic              z_flag,
  output logic              br_taken
);

  typedef enum logic [3:0] {
    OP_NOP, OP_MOV, OP_INC, OP_DEC,
    OP_VLO, OP_VHI, OP_SHLI, OP_SETB,
    OP_FLIPB, OP_FSHL, OP_FSHR, OP_BIZ,
    OP_BNZ
  } op_e;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic          hold_valid;
  logic [3:0]    hold_op;
  logic [AW-1:0] hold_dst;
  logic [AW-1:0] hold_src;
  logic [3:0]    hold_imm;

  logic          p_valid;
  op_e           p_op;
  logic [AW-1:0] p_dst;
  logic [AW-1:0] p_src;
  logic [3:0]    p_imm;
  logic          p_write;
  logic          exec;
  logic          capture;
  logic          hold_nxt;
  logic          sh_ok;
  logic          is_zop;
  logic          is_br;
  logic          br_val;

  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W-1:0]   imm_w;
  logic [DATA_W-1:0]   mask;
  logic [DATA_W-1:0]   res;
  logic [2*DATA_W-1:0] fl;
  logic [2*DATA_W-1:0] fr;

  function automatic logic zr(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] rd(input logic [AW-1:0] a);
    if (zr(a)) return '0;
    return regs[a];
  endfunction

  assign rd_data_a = rd(rd_addr_a);
  assign rd_data_b = rd(rd_addr_b);
  assign stall     = hold_valid;

  // A full hold buffer masks the decoder input entirely.
  always_comb begin
    p_valid = hold_valid | op_valid;
    p_op    = op_e'(hold_valid ? hold_op : op);
    p_dst   = hold_valid ? hold_dst : dst;
    p_src   = hold_valid ? hold_src : src;
    p_imm   = hold_valid ? hold_imm : imm;
    p_write = p_valid && (p_op != OP_NOP) && (p_op <= OP_FSHR);
    exec    = p_valid && !(ld_valid && p_write);
    capture = !hold_valid && op_valid && ld_valid && p_write;
    hold_nxt = hold_valid ? ld_valid : capture;
  end

  always_comb begin
    opa   = rd(p_dst);
    opb   = rd(p_src);
    sh_ok = int'(p_imm) < DATA_W;
    imm_w = DATA_W'(p_imm);
    mask  = DATA_W'(1) << p_imm;
    fl    = {opa, opb} << p_imm;
    fr    = {opb, opa} >> p_imm;
    res   = opa;
    unique case (p_op)
      OP_MOV:   res = (p_src == p_dst) ? '0 : opb;
      OP_INC:   res = opb + DATA_W'(1);
      OP_DEC:   res = opb - DATA_W'(1);
      OP_VLO:   res = (opa & ~DATA_W'(15)) | imm_w;
      OP_VHI:   res = (opa & ~(DATA_W'(15) << 4)) | (imm_w << 4);
      OP_SHLI:  res = {opa[DATA_W-5:0], p_imm};
      OP_SETB:  if (sh_ok) res = opa | mask;
      OP_FLIPB: if (sh_ok) res = opa ^ mask;
      OP_FSHL:  if (sh_ok) res = fl[2*DATA_W-1:DATA_W];
      OP_FSHR:  if (sh_ok) res = fr[DATA_W-1:0];
      default:  res = opa;
    endcase
    is_zop = (p_op == OP_MOV) || (p_op == OP_INC) || (p_op == OP_DEC);
    is_br  = (p_op == OP_BIZ) || (p_op == OP_BNZ);
    br_val = (p_op == OP_BIZ) ? (opb == '0) : (opb != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      hold_valid <= 1'b0;
      hold_op    <= '0;
      hold_dst   <= '0;
      hold_src   <= '0;
      hold_imm   <= '0;
      z_flag     <= 1'b0;
      br_taken   <= 1'b0;
    end else begin
      if (ld_valid && !zr(ld_dst)) regs[ld_dst] <= ld_data;
      if (exec && p_write && !zr(p_dst)) regs[p_dst] <= res;
      if (exec && is_zop) z_flag <= (res == '0);
      br_taken   <= exec && is_br && br_val;
      hold_valid <= hold_nxt;
      if (capture) begin
        hold_op  <= op;
        hold_dst <= dst;
        hold_src <= src;
        hold_imm <= imm;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: immediates, arithmetic, funnel shifts,
// load/op arbitration with the hold buffer, zero register and async reset.
module tb_reg_file_param;

  localparam int DW = 8;
  localparam int AW = 4;

  localparam logic [3:0] MOV = 4'd1, INC = 4'd2, DEC = 4'd3;
  localparam logic [3:0] VLO = 4'd4, VHI = 4'd5, SHLI = 4'd6;
  localparam logic [3:0] SETB = 4'd7, FLIPB = 4'd8;
  localparam logic [3:0] FSHL = 4'd9, FSHR = 4'd10;
  localparam logic [3:0] BIZ = 4'd11, BNZ = 4'd12;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid;
  logic [3:0]    op;
  logic [AW-1:0] dst;
  logic [AW-1:0] src;
  logic [3:0]    imm;
  logic [AW-1:0] rd_addr_a;
  logic [DW-1:0] rd_data_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_b;
  logic          ld_valid;
  logic [AW-1:0] ld_dst;
  logic [DW-1:0] ld_data;
  logic          stall;
  logic          z_flag;
  logic          br_taken;

  int checks = 0;
  int errors = 0;

  reg_file_param #(
    .DATA_W(DW), .NUM_REGS(16), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op(op), .dst(dst), .src(src), .imm(imm),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_data(ld_data),
    .stall(stall), .z_flag(z_flag), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    rd_addr_a = a;
    #1;
    d = rd_data_a;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_valid = 1'b1; ld_dst = a; ld_data = d;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] o, input logic [AW-1:0] d,
                       input logic [AW-1:0] s, input logic [3:0] i);
    op_valid = 1'b1; op = o; dst = d; src = s; imm = i;
    step();
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    rd(4'd3, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL reset_r3 got %h exp 00", v);
    end
    checks++;
    if ({stall, z_flag, br_taken} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000", {stall, z_flag, br_taken});
    end
  endtask

  task automatic test_imm();
    logic [DW-1:0] v;
    do_op(VLO, 4'd3, 4'd0, 4'h5);
    do_op(VHI, 4'd3, 4'd0, 4'hA);
    rd(4'd3, v);
    checks++;
    if (v !== 8'hA5) begin
      errors++; $display("FAIL vlo_vhi got %h exp a5", v);
    end
    do_op(SHLI, 4'd3, 4'd0, 4'hC);
    rd(4'd3, v);
    checks++;
    if (v !== 8'h5C) begin
      errors++; $display("FAIL shli got %h exp 5c", v);
    end
  endtask

  task automatic test_incdec();
    logic [DW-1:0] v;
    load(4'd4, 8'hFF);
    load(4'd6, 8'h33);
    do_op(INC, 4'd4, 4'd4, 4'd0);
    rd(4'd4, v);
    checks++;
    if (v !== 8'h00 || z_flag !== 1'b1) begin
      errors++; $display("FAIL inc_wrap got %h z=%b exp 00 z=1", v, z_flag);
    end
    do_op(DEC, 4'd5, 4'd4, 4'd0);
    rd(4'd5, v);
    checks++;
    if (v !== 8'hFF || z_flag !== 1'b0) begin
      errors++; $display("FAIL dec_wrap got %h z=%b exp ff z=0", v, z_flag);
    end
    do_op(MOV, 4'd6, 4'd6, 4'd0);
    rd(4'd6, v);
    checks++;
    if (v !== 8'h00 || z_flag !== 1'b1) begin
      errors++; $display("FAIL mov_self got %h z=%b exp 00 z=1", v, z_flag);
    end
    do_op(VLO, 4'd6, 4'd0, 4'h7);
    checks++;
    if (z_flag !== 1'b1) begin
      errors++; $display("FAIL z_hold got %b exp 1", z_flag);
    end
  endtask

  task automatic test_funnel();
    logic [DW-1:0] v;
    load(4'd1, 8'h81);
    load(4'd2, 8'hF0);
    do_op(FSHL, 4'd1, 4'd2, 4'd4);
    rd(4'd1, v);
    checks++;
    if (v !== 8'h1F) begin
      errors++; $display("FAIL fshl got %h exp 1f", v);
    end
    do_op(FSHR, 4'd1, 4'd2, 4'd4);
    rd(4'd1, v);
    checks++;
    if (v !== 8'h01) begin
      errors++; $display("FAIL fshr got %h exp 01", v);
    end
    do_op(SETB, 4'd1, 4'd0, 4'd9);
    rd(4'd1, v);
    checks++;
    if (v !== 8'h01) begin
      errors++; $display("FAIL setb_oob got %h exp 01", v);
    end
    do_op(SETB, 4'd1, 4'd0, 4'd7);
    do_op(FLIPB, 4'd1, 4'd0, 4'd0);
    rd(4'd1, v);
    checks++;
    if (v !== 8'h80) begin
      errors++; $display("FAIL setb_flipb got %h exp 80", v);
    end
    do_op(FSHL, 4'd1, 4'd2, 4'd8);
    rd(4'd1, v);
    checks++;
    if (v !== 8'h80) begin
      errors++; $display("FAIL fshl_oob got %h exp 80", v);
    end
    do_op(FSHR, 4'd1, 4'd2, 4'd0);
    rd(4'd1, v);
    checks++;
    if (v !== 8'h80) begin
      errors++; $display("FAIL fshr_zero got %h exp 80", v);
    end
  endtask

  task automatic test_hold();
    logic [DW-1:0] v;
    load(4'd2, 8'h05);
    load(4'd7, 8'h00);
    ld_valid = 1'b1; ld_dst = 4'd2; ld_data = 8'h10;
    do_op(INC, 4'd7, 4'd2, 4'd0);
    ld_valid = 1'b0;
    rd_addr_b = 4'd7;
    rd(4'd2, v);
    checks++;
    if (stall !== 1'b1 || v !== 8'h10 || rd_data_b !== 8'h00) begin
      errors++;
      $display("FAIL hold_cap stall=%b r2=%h r7=%h exp 1 10 00",
               stall, v, rd_data_b);
    end
    step();
    rd(4'd7, v);
    checks++;
    if (stall !== 1'b0 || v !== 8'h11) begin
      errors++; $display("FAIL hold_ret stall=%b r7=%h exp 0 11", stall, v);
    end
    ld_valid = 1'b1; ld_dst = 4'd2; ld_data = 8'h20;
    do_op(INC, 4'd7, 4'd2, 4'd0);
    ld_dst = 4'd3; ld_data = 8'h77;
    do_op(INC, 4'd8, 4'd8, 4'd0);
    ld_valid = 1'b0;
    rd(4'd7, v);
    checks++;
    if (stall !== 1'b1 || v !== 8'h11) begin
      errors++; $display("FAIL hold_defer stall=%b r7=%h exp 1 11", stall, v);
    end
    step();
    rd(4'd7, v);
    checks++;
    if (stall !== 1'b0 || v !== 8'h21) begin
      errors++; $display("FAIL hold_ret2 stall=%b r7=%h exp 0 21", stall, v);
    end
    step();
    rd(4'd8, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL hold_ignored r8 got %h exp 00", v);
    end
    rd(4'd3, v);
    checks++;
    if (v !== 8'h77) begin
      errors++; $display("FAIL ld_during_hold r3 got %h exp 77", v);
    end
    ld_valid = 1'b1; ld_dst = 4'd9; ld_data = 8'h01;
    do_op(BNZ, 4'd0, 4'd2, 4'd0);
    ld_valid = 1'b0;
    checks++;
    if (br_taken !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL br_with_ld br=%b stall=%b exp 1 0", br_taken, stall);
    end
  endtask

  task automatic test_zero();
    logic [DW-1:0] v;
    do_op(BIZ, 4'd0, 4'd0, 4'd0);
    checks++;
    if (br_taken !== 1'b1) begin
      errors++; $display("FAIL biz_r0 got %b exp 1", br_taken);
    end
    step();
    checks++;
    if (br_taken !== 1'b0) begin
      errors++; $display("FAIL br_pulse got %b exp 0", br_taken);
    end
    do_op(MOV, 4'd0, 4'd3, 4'd0);
    rd(4'd0, v);
    checks++;
    if (v !== 8'h00 || z_flag !== 1'b0) begin
      errors++; $display("FAIL mov_r0 got %h z=%b exp 00 z=0", v, z_flag);
    end
    load(4'd0, 8'h55);
    rd(4'd0, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL ld_r0 got %h exp 00", v);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [DW-1:0] v;
    do_op(MOV, 4'd10, 4'd10, 4'd0);
    ld_valid = 1'b1; ld_dst = 4'd11; ld_data = 8'h42;
    do_op(INC, 4'd9, 4'd5, 4'd0);
    ld_valid = 1'b0;
    checks++;
    if (stall !== 1'b1 || z_flag !== 1'b1) begin
      errors++; $display("FAIL pre_rst stall=%b z=%b exp 1 1", stall, z_flag);
    end
    reset = 1'b1;
    rd(4'd5, v);
    checks++;
    if ({stall, z_flag, br_taken} !== 3'b000 || v !== 8'h00) begin
      errors++;
      $display("FAIL async_rst flags=%b r5=%h exp 000 00",
               {stall, z_flag, br_taken}, v);
    end
    step();
    reset = 1'b0;
    step();
    step();
    rd(4'd9, v);
    checks++;
    if (v !== 8'h00 || stall !== 1'b0) begin
      errors++; $display("FAIL held_dropped r9=%h stall=%b exp 00 0", v, stall);
    end
  endtask

  initial begin
    reset = 1'b1;
    op_valid = 1'b0; op = '0; dst = '0; src = '0; imm = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    ld_valid = 1'b0; ld_dst = '0; ld_data = '0;
    test_reset();
    test_imm();
    test_incdec();
    test_funnel();
    test_hold();
    test_zero();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
